// File: rtl/ddr4_pkg.sv
// ddr4_pkg
// Shared types and constants for the simplified DDR4 command controller.
// Contents:
//   state_t    - controller FSM states
//   cmd_t      - decoded command from the command pins
//   HIGH/LOW   - single-bit level constants
//   NUM_BANKS  - banks in the single rank (2 groups x 4 banks)
//   BANK_BITS  - width of the flattened bank index
//   decode_cmd - priority decode of refresh/ACT_n/RAS_n/CAS_n/WE_n
package ddr4_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        WRITE,
        READ,
        PRECHARGE,
        REFRESH
    } state_t;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        WR,
        RD,
        PRE,
        REF
    } cmd_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int NUM_BANKS = 8;
    localparam int BANK_BITS = 3;

    // The dedicated refresh request outranks everything; ACT_n low turns
    // the RAS/CAS/WE pins into row bits, so they only decode as a command
    // when ACT_n is high.
    function automatic cmd_t decode_cmd(input logic refresh,
                                        input logic act_n,
                                        input logic ras_n,
                                        input logic cas_n,
                                        input logic we_n);
        cmd_t cmd;
        cmd = NOP;
        if (refresh == HIGH) begin
            cmd = REF;
        end else if (act_n == LOW) begin
            cmd = ACT;
        end else begin
            case ({ras_n, cas_n, we_n})
                3'b100:  cmd = WR;
                3'b101:  cmd = RD;
                3'b010:  cmd = PRE;
                3'b001:  cmd = REF;
                default: cmd = NOP;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ddr4_mem_array.sv
// ddr4_mem_array
// Behavioural 16-bit storage for the controller, addressed by the
// concatenation {bank, row, col}. Writes land on the rising clock edge,
// reads are combinational so the controller can capture the word on the
// same edge it accepts a READ. The array has no reset: contents survive
// controller reset and refresh.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   addr     in   {bank,row,col} word address (shared by read and write)
//   wr_data  in   word to store
//   rd_data  out  word currently stored at addr
module ddr4_mem_array #(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wr_data,
    output logic [15:0]          rd_data
);

    logic [15:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/ddr4_cmd_controller.sv
// ddr4_cmd_controller
// Simplified single-rank DDR4-style command controller with an internal
// storage array. Decodes the command pins, tracks one open row per bank,
// and performs single-beat 16-bit writes and reads with a fixed read
// latency of CL clocks.
// Ports:
//   clk                in   clock, rising edge
//   reset_n            in   synchronous active-low reset
//   act_n              in   activate, active-low
//   refresh            in   refresh request, active-high
//   bank_group_select  in   bank group (upper bank index bit)
//   bank_select[1:0]   in   bank within group
//   ras_n_a16          in   RAS_n / row bit 16
//   cas_n_a15          in   CAS_n / row bit 15
//   we_n_a14           in   WE_n  / row bit 14
//   a13, a11           in   row bits, unused here (row comes from row_addr)
//   bc_n_a12           in   burst chop, unused (burst length is 1)
//   ap_a10             in   auto-precharge on READ/WRITE, all-banks on PRECHARGE
//   a9_0[9:0]          in   column address
//   row_addr[16:0]     in   row address sampled on ACTIVATE
//   data_in[15:0]      in   write data
//   data_out[15:0]     out  registered read data
module ddr4_cmd_controller
    import ddr4_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int CL       = 2,
    parameter int TRFC     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        act_n,
    input  logic        refresh,
    input  logic        bank_group_select,
    input  logic [1:0]  bank_select,
    input  logic        ras_n_a16,
    input  logic        cas_n_a15,
    input  logic        we_n_a14,
    input  logic        a13,
    input  logic        bc_n_a12,
    input  logic        a11,
    input  logic        ap_a10,
    input  logic [9:0]  a9_0,
    input  logic [16:0] row_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out
);

    localparam int CNT_W     = 8;
    localparam int ADDR_BITS = BANK_BITS + ROW_BITS + COL_BITS;

    state_t                present_state_q, present_state_d;
    logic [NUM_BANKS-1:0]  valid_q, valid_d;
    logic [ROW_BITS-1:0]   open_row_q [NUM_BANKS];
    logic [ROW_BITS-1:0]   open_row_d [NUM_BANKS];
    logic [15:0]           data_out_q, data_out_d;
    logic [15:0]           rd_data_q, rd_data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [BANK_BITS-1:0]  bank;
    logic [COL_BITS-1:0]   col;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [15:0]           mem_rd_data;
    logic                  mem_wr_en;
    logic                  accept;
    logic                  bank_open;
    cmd_t                  cmd;
    logic                  unused_pins;

    // Row bits carried on the command pins and beyond ROW_BITS/COL_BITS
    // alias away; only row_addr and the low column bits index storage.
    assign unused_pins = ^{a13, bc_n_a12, a11, a9_0[9:COL_BITS],
                           row_addr[16:ROW_BITS]};

    assign bank      = {bank_group_select, bank_select};
    assign col       = a9_0[COL_BITS-1:0];
    assign cmd       = decode_cmd(refresh, act_n, ras_n_a16, cas_n_a15, we_n_a14);
    assign accept    = (present_state_q == IDLE) || (present_state_q == ACTIVE);
    assign bank_open = valid_q[bank];
    assign mem_addr  = {bank, open_row_q[bank], col};
    assign mem_wr_en = accept && (cmd == WR) && bank_open;
    assign data_out  = data_out_q;

    ddr4_mem_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .addr    (mem_addr),
        .wr_data (data_in),
        .rd_data (mem_rd_data)
    );

    // Next-state logic. Commands are only taken in IDLE/ACTIVE; every other
    // state is a fixed-length busy period. Bank-closing side effects
    // (auto-precharge, precharge, refresh) are applied on the accepting edge
    // so the return state can simply look at the valid bits afterwards.
    // A read captures the word when accepted and releases it to data_out
    // after the CL-clock countdown.
    always_comb begin
        present_state_d = present_state_q;
        valid_d         = valid_q;
        open_row_d      = open_row_q;
        data_out_d      = data_out_q;
        rd_data_d       = rd_data_q;
        cnt_d           = cnt_q;

        case (present_state_q)
            IDLE, ACTIVE: begin
                case (cmd)
                    REF: begin
                        valid_d         = '0;
                        cnt_d           = CNT_W'(TRFC - 1);
                        present_state_d = REFRESH;
                    end
                    ACT: begin
                        open_row_d[bank] = row_addr[ROW_BITS-1:0];
                        valid_d[bank]    = HIGH;
                        present_state_d  = ACTIVE;
                    end
                    WR: begin
                        if (bank_open) begin
                            if (ap_a10 == HIGH) begin
                                valid_d[bank] = LOW;
                            end
                            present_state_d = WRITE;
                        end
                    end
                    RD: begin
                        if (bank_open) begin
                            rd_data_d = mem_rd_data;
                            cnt_d     = CNT_W'(CL - 1);
                            if (ap_a10 == HIGH) begin
                                valid_d[bank] = LOW;
                            end
                            present_state_d = READ;
                        end
                    end
                    PRE: begin
                        if (ap_a10 == HIGH) begin
                            valid_d = '0;
                        end else begin
                            valid_d[bank] = LOW;
                        end
                        present_state_d = PRECHARGE;
                    end
                    default: begin
                        present_state_d = present_state_q;
                    end
                endcase
            end
            WRITE, PRECHARGE: begin
                present_state_d = (|valid_q) ? ACTIVE : IDLE;
            end
            READ: begin
                if (cnt_q == '0) begin
                    data_out_d      = rd_data_q;
                    present_state_d = (|valid_q) ? ACTIVE : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REFRESH: begin
                if (cnt_q == '0) begin
                    present_state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                present_state_d = IDLE;
            end
        endcase
    end

    // State register. Reset drops any in-flight read by clearing the
    // countdown and captured word along with the state.
    always_ff @(posedge clk) begin
        if (reset_n == LOW) begin
            present_state_q <= IDLE;
            valid_q         <= '0;
            open_row_q      <= '{default: '0};
            data_out_q      <= 16'h0000;
            rd_data_q       <= 16'h0000;
            cnt_q           <= '0;
        end else begin
            present_state_q <= present_state_d;
            valid_q         <= valid_d;
            open_row_q      <= open_row_d;
            data_out_q      <= data_out_d;
            rd_data_q       <= rd_data_d;
            cnt_q           <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_controller.sv
// tb_ddr4_cmd_controller
// Directed self-checking bench for ddr4_cmd_controller. Drives commands one
// clock at a time, checks data_out and the controller state against
// hand-computed values, and prints a one-line summary.
module tb_ddr4_cmd_controller;
    import ddr4_pkg::*;

    localparam int CL   = 2;
    localparam int TRFC = 4;

    logic        clk;
    logic        reset_n;
    logic        act_n;
    logic        refresh;
    logic        bank_group_select;
    logic [1:0]  bank_select;
    logic        ras_n_a16;
    logic        cas_n_a15;
    logic        we_n_a14;
    logic        a13;
    logic        bc_n_a12;
    logic        a11;
    logic        ap_a10;
    logic [9:0]  a9_0;
    logic [16:0] row_addr;
    logic [15:0] data_in;
    logic [15:0] data_out;

    int          checks;
    int          errors;
    logic [15:0] expOut;

    ddr4_cmd_controller #(
        .ROW_BITS (4),
        .COL_BITS (4),
        .CL       (CL),
        .TRFC     (TRFC)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .act_n             (act_n),
        .refresh           (refresh),
        .bank_group_select (bank_group_select),
        .bank_select       (bank_select),
        .ras_n_a16         (ras_n_a16),
        .cas_n_a15         (cas_n_a15),
        .we_n_a14          (we_n_a14),
        .a13               (a13),
        .bc_n_a12          (bc_n_a12),
        .a11               (a11),
        .ap_a10            (ap_a10),
        .a9_0              (a9_0),
        .row_addr          (row_addr),
        .data_in           (data_in),
        .data_out          (data_out)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle 1 unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setNop();
        act_n     = 1'b1;
        refresh   = 1'b0;
        ras_n_a16 = 1'b1;
        cas_n_a15 = 1'b1;
        we_n_a14  = 1'b1;
        a13       = 1'b0;
        bc_n_a12  = 1'b1;
        a11       = 1'b0;
        ap_a10    = 1'b0;
    endtask

    // Present one command for exactly one edge, then return to NOP.
    task automatic applyStimulus(input cmd_t c, input logic [2:0] bank,
                                 input logic [16:0] row, input logic [9:0] col,
                                 input logic [15:0] data, input logic ap);
        setNop();
        {bank_group_select, bank_select} = bank;
        row_addr = row;
        a9_0     = col;
        data_in  = data;
        ap_a10   = ap;
        case (c)
            ACT: begin
                act_n = 1'b0;
                {ras_n_a16, cas_n_a15, we_n_a14} = row[16:14];
                a13 = row[13];
                a11 = row[11];
            end
            WR:      {ras_n_a16, cas_n_a15, we_n_a14} = 3'b100;
            RD:      {ras_n_a16, cas_n_a15, we_n_a14} = 3'b101;
            PRE:     {ras_n_a16, cas_n_a15, we_n_a14} = 3'b010;
            REF:     refresh = 1'b1;
            default: ;
        endcase
        tick();
        setNop();
    endtask

    function automatic logic [15:0] st(input state_t s);
        return 16'(s);
    endfunction

    task automatic doActivate(input logic [2:0] bank, input logic [16:0] row);
        applyStimulus(ACT, bank, row, 10'd0, 16'h0000, 1'b0);
        checkOutput("act_state", st(dut.present_state_q), st(ACTIVE));
    endtask

    task automatic doWrite(input logic [2:0] bank, input logic [9:0] col,
                           input logic [15:0] data, input logic ap,
                           input state_t retState);
        applyStimulus(WR, bank, 17'd0, col, data, ap);
        checkOutput("wr_state", st(dut.present_state_q), st(WRITE));
        tick();
        checkOutput("wr_return", st(dut.present_state_q), st(retState));
    endtask

    // data_out must hold its old value until exactly CL edges after the
    // accepting edge, then show the new word.
    task automatic doRead(input logic [2:0] bank, input logic [9:0] col,
                          input logic [15:0] expected, input state_t retState);
        applyStimulus(RD, bank, 17'd0, col, 16'h0000, 1'b0);
        checkOutput("rd_state", st(dut.present_state_q), st(READ));
        checkOutput("rd_hold", data_out, expOut);
        for (int i = 1; i < CL; i++) begin
            tick();
            checkOutput("rd_hold", data_out, expOut);
        end
        tick();
        expOut = expected;
        checkOutput("rd_data", data_out, expOut);
        checkOutput("rd_return", st(dut.present_state_q), st(retState));
    endtask

    task automatic doRefresh();
        applyStimulus(REF, 3'd0, 17'd0, 10'd0, 16'h0000, 1'b0);
        checkOutput("ref_state", st(dut.present_state_q), st(REFRESH));
        for (int i = 1; i < TRFC; i++) begin
            tick();
            checkOutput("ref_state", st(dut.present_state_q), st(REFRESH));
        end
        tick();
        checkOutput("ref_done", st(dut.present_state_q), st(IDLE));
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        expOut            = 16'h0000;
        reset_n           = 1'b0;
        bank_group_select = 1'b0;
        bank_select       = 2'd0;
        a9_0              = 10'd0;
        row_addr          = 17'd0;
        data_in           = 16'h0000;
        setNop();

        // Reset for three clocks, then a one-clock refresh.
        repeat (3) tick();
        checkOutput("rst_data", data_out, 16'h0000);
        checkOutput("rst_state", st(dut.present_state_q), st(IDLE));
        reset_n = 1'b1;
        doRefresh();
        checkOutput("ref_data", data_out, 16'h0000);

        // Group0/bank0.
        doActivate(3'd0, 17'd0);
        doWrite(3'd0, 10'd2, 16'hFF00, 1'b0, ACTIVE);
        doRead(3'd0, 10'd2, 16'hFF00, ACTIVE);

        // Group1/bank1, then bank0 still intact.
        doActivate(3'd5, 17'd0);
        doWrite(3'd5, 10'd1, 16'hAFBC, 1'b0, ACTIVE);
        doRead(3'd5, 10'd1, 16'hAFBC, ACTIVE);
        doRead(3'd0, 10'd2, 16'hFF00, ACTIVE);

        // Re-activate bank0, write/read col 3, refresh preserves storage.
        doActivate(3'd0, 17'd0);
        doWrite(3'd0, 10'd3, 16'h7654, 1'b0, ACTIVE);
        doRead(3'd0, 10'd3, 16'h7654, ACTIVE);
        doRefresh();

        // Refresh closed every bank: a read is ignored.
        applyStimulus(RD, 3'd0, 17'd0, 10'd3, 16'h0000, 1'b0);
        checkOutput("rd_closed_state", st(dut.present_state_q), st(IDLE));
        repeat (CL) tick();
        checkOutput("rd_closed_data", data_out, expOut);

        // Upper row bits alias onto row 0.
        doActivate(3'd0, 17'h1_0000);
        doRead(3'd0, 10'd3, 16'h7654, ACTIVE);

        // Precharge all banks.
        applyStimulus(PRE, 3'd0, 17'd0, 10'd0, 16'h0000, 1'b1);
        checkOutput("pre_state", st(dut.present_state_q), st(PRECHARGE));
        tick();
        checkOutput("pre_return", st(dut.present_state_q), st(IDLE));

        // Seed group1/bank0 with auto-precharge, then a write with no open
        // row must leave it unchanged.
        doActivate(3'd4, 17'd0);
        doWrite(3'd4, 10'd0, 16'h0BAD, 1'b1, IDLE);
        applyStimulus(WR, 3'd4, 17'd0, 10'd0, 16'h1234, 1'b0);
        checkOutput("wr_closed_state", st(dut.present_state_q), st(IDLE));
        doActivate(3'd4, 17'd0);
        doRead(3'd4, 10'h010, 16'h0BAD, ACTIVE);

        // Single-bank precharge.
        applyStimulus(PRE, 3'd4, 17'd0, 10'd0, 16'h0000, 1'b0);
        checkOutput("pre1_state", st(dut.present_state_q), st(PRECHARGE));
        tick();
        checkOutput("pre1_return", st(dut.present_state_q), st(IDLE));

        // Reset one clock after a READ: the read never arrives.
        doActivate(3'd4, 17'd0);
        applyStimulus(RD, 3'd4, 17'd0, 10'd1, 16'h0000, 1'b0);
        checkOutput("rdrst_state", st(dut.present_state_q), st(READ));
        reset_n = 1'b0;
        tick();
        expOut = 16'h0000;
        checkOutput("rdrst_data", data_out, expOut);
        checkOutput("rdrst_idle", st(dut.present_state_q), st(IDLE));
        reset_n = 1'b1;
        repeat (CL + 1) tick();
        checkOutput("rdrst_nodeliver", data_out, expOut);
        checkOutput("rdrst_state2", st(dut.present_state_q), st(IDLE));

        // Reset closed the bank as well.
        applyStimulus(RD, 3'd4, 17'd0, 10'd0, 16'h0000, 1'b0);
        checkOutput("rdrst_closed", st(dut.present_state_q), st(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr4_cmd_controller.md
Name: ddr4_cmd_controller

Overview:
- Simplified single-rank DDR4-style command controller with a built-in behavioural storage array.
- Decodes ACT_n/RAS_n/CAS_n/WE_n command pins plus a dedicated refresh request.
- Tracks the open row per bank and performs single-beat 16-bit writes and reads.
- Sits between a host-side command driver/bench and the system-level memory model; no external DRAM interface.

Parameters:
- ROW_BITS, 4: row address bits stored (low bits of row_addr); rows = 2**ROW_BITS.
- COL_BITS, 4: column bits stored (low bits of a9_0); columns = 2**COL_BITS.
- CL, 2: read latency in clocks from READ acceptance to data_out update.
- TRFC, 4: clocks spent in REFRESH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- act_n  in  1  activate command, active-low.
- refresh  in  1  refresh request, active-high.
- bank_group_select  in  1  bank group (0..1).
- bank_select  in  2  bank within group (0..3); bank index = {bank_group_select, bank_select}.
- ras_n_a16  in  1  RAS_n when act_n=1; row bit 16 when act_n=0.
- cas_n_a15  in  1  CAS_n / row bit 15.
- we_n_a14  in  1  WE_n / row bit 14.
- a13  in  1  row bit 13; otherwise ignored.
- bc_n_a12  in  1  burst chop; ignored (burst length fixed at 1).
- a11  in  1  row bit 11; otherwise ignored.
- ap_a10  in  1  auto-precharge on READ/WRITE when 1.
- a9_0  in  10  column address.
- row_addr  in  17  row address, sampled on ACTIVATE.
- data_in  in  16  write data.
- data_out  out  16  read data, registered.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - present_state=IDLE; all 8 open-row valid bits cleared; data_out=16'h0000; refresh counter and read pipeline cleared.
  - Storage array is not cleared.
  - Reset mid-operation aborts everything; a pending read is never delivered.
- Command decode, sampled each edge in IDLE or ACTIVE, highest priority first:
  - refresh=1: REFRESH.
  - act_n=0: ACTIVATE.
  - act_n=1 with {ras_n,cas_n,we_n}:
    - 1,0,0: WRITE.
    - 1,0,1: READ.
    - 0,1,0: PRECHARGE (ap_a10=1 means all banks).
    - 0,0,1: REFRESH.
    - anything else: NOP.
- States: IDLE (no row open), ACTIVE (at least one row open), WRITE, READ, PRECHARGE, REFRESH. present_state and next_state are internal registers.
- ACTIVATE:
  - Stores row_addr[ROW_BITS-1:0] as the bank's open row and sets its valid bit in the same cycle; next state ACTIVE.
  - ACTIVATE to an already-open bank replaces the row (implicit precharge).
- WRITE (1 clock):
  - Stores data_in at [bank][open_row][a9_0[COL_BITS-1:0]] at that edge.
  - Ignored (NOP) if the bank has no open row.
- READ:
  - Reads the same address; data_out updates exactly CL clocks after acceptance and holds until the next read completes.
  - Ignored if the bank has no open row.
  - New commands are not accepted until data_out updates.
- Auto-precharge: with ap_a10=1 on READ/WRITE, the bank closes after the access.
- PRECHARGE (1 clock): clears the valid bit for the selected bank, or all banks.
- REFRESH:
  - Closes all banks and stays TRFC clocks; all inputs ignored meanwhile; storage preserved.
  - Then goes to IDLE.
  - A refresh held high re-enters REFRESH.
- Return state: after WRITE/READ/PRECHARGE, next state is ACTIVE if any valid bit is set, else IDLE.
- Held inputs: commands are level-sampled. Holding WRITE re-writes the same word each accepted cycle (idempotent). Holding ACTIVATE re-opens the same row.
- Address widths: upper row/column bits beyond ROW_BITS/COL_BITS are ignored (aliasing).

Decomposition:
- Package ddr4_pkg:
  - state_t enum (IDLE, ACTIVE, WRITE, READ, PRECHARGE, REFRESH).
  - cmd_t enum (NOP, ACT, WR, RD, PRE, REF).
  - HIGH/LOW constants.
  - NUM_BANKS=8.
- One sub-module, ddr4_mem_array: 16-bit synchronous-write, combinational-read storage indexed by {bank,row,col}.

Test Plan:
- Reset then refresh: reset_n=0 for 3 clocks, release, refresh=1 for 1 clock -> data_out=0000, TRFC clocks in REFRESH, then IDLE.
- Group0/bank0 path: ACTIVATE row 0, WRITE col 2 data_in=FF00, READ col 2 -> data_out=FF00 exactly CL clocks after READ.
- Group1/bank1 path: ACTIVATE row 0, WRITE col 1 AFBC, READ col 1 -> AFBC; bank0 col 2 still reads FF00.
- Re-activate group0/bank0 row 0, WRITE col 3 7654, READ col 3 -> 7654. Then refresh, re-activate, read col 3 -> 7654 preserved.
- WRITE to group1/bank0 with no row opened -> storage unchanged; a later ACTIVATE plus READ returns the prior value.
- Issue a READ, assert reset_n=0 one clock later -> data_out=0000, the read is never delivered, state IDLE.
